// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default frame format and
// the sTick counter landmarks used by both the receiver and transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam int unsigned DATA_BITS_DEF = 8;
    localparam int unsigned SB_TICK_DEF   = 16;

    localparam logic [3:0] MID_TICK  = 4'd7;
    localparam logic [3:0] LAST_TICK = 4'd15;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the
// idle-high level so no false start edge appears out of reset.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_oversampled.sv
// 16x-oversampled UART receiver (8N1 by default). Define UART_RX_PARITY_EN
// to add an even-parity bit after the data bits and the parityErr output.
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = DATA_BITS_DEF,
    parameter int unsigned SB_TICK   = SB_TICK_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sTick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 rxDoneTick,
    output logic                 frameErr
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parityErr
`endif
);

    localparam int unsigned   NW        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [NW-1:0] N_LAST    = NW'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(SB_TICK - 1);

    logic rxS;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rx),
        .q_o   (rxS)
    );

    uart_state_e          state_q, state_d;
    logic [3:0]           s_q, s_d;
    logic [NW-1:0]        n_q, n_d;
    logic [DATA_BITS-1:0] b_q, b_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 done_q, done_d;
    logic                 ferr_q, ferr_d;
    logic                 armed_q, armed_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_q, par_d;
    logic                 perr_q, perr_d;
`endif

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        ferr_d  = ferr_q;
        armed_d = armed_q;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = perr_q;
`endif
        unique case (state_q)
            // A frame that ended on a low line (break) must see the line
            // return high before another start edge is accepted.
            IDLE: begin
                if (rxS) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (sTick) begin
                    if (s_q == MID_TICK) begin
                        if (!rxS) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (sTick) begin
                    if (s_q == LAST_TICK) begin
                        s_d = '0;
                        b_d = {rxS, b_q[DATA_BITS-1:1]};
                        if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (sTick) begin
                    if (s_q == LAST_TICK) begin
                        s_d     = '0;
                        par_d   = rxS;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
`endif
            STOP: begin
                if (sTick) begin
                    if (s_q == STOP_LAST) begin
                        dout_d  = b_q;
                        ferr_d  = ~rxS;
                        armed_d = rxS;
                        done_d  = 1'b1;
                        state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                        perr_d  = ^{b_q, par_q};
`endif
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            armed_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
            armed_q <= armed_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign dout       = dout_q;
    assign rxDoneTick = done_q;
    assign frameErr   = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign parityErr  = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: frames are driven bit by bit on rx,
// expected words are queued before sending and checked on each rxDoneTick.
module tb_uart_rx_oversampled;

`ifdef UART_RX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int FRAME_CLKS = (8 + 16 * (8 + PBITS) + 16) * 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       sTick = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] dout;
    logic       rxDoneTick;
    logic       frameErr;
`ifdef UART_RX_PARITY_EN
    logic       parityErr;
    logic       par_flip = 1'b0;
`endif

    uart_rx_oversampled #(
        .DATA_BITS (8),
        .SB_TICK   (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sTick      (sTick),
        .rx         (rx),
        .dout       (dout),
        .rxDoneTick (rxDoneTick),
        .frameErr   (frameErr)
`ifdef UART_RX_PARITY_EN
        ,
        .parityErr  (parityErr)
`endif
    );

    always #5 clk = ~clk;

    logic [1:0] tick_cnt = 2'd0;
    always @(posedge clk) begin
        tick_cnt <= tick_cnt + 2'd1;
        sTick    <= (tick_cnt == 2'd3);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   done_cyc[$];
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   done_count = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rxDoneTick === 1'b1) begin
            done_count++;
            done_cyc.push_back(cyc);
            check("done_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("dout", 32'(dout), 32'(mon_e.data));
                check("frameErr", 32'(frameErr), 32'(mon_e.ferr));
`ifdef UART_RX_PARITY_EN
                check("parityErr", 32'(parityErr), 32'(mon_e.perr));
`endif
            end
        end
    end

    task automatic push(input logic [7:0] d, input logic ferr, input logic perr);
        exp_t e;
        e.data = d;
        e.ferr = ferr;
        e.perr = perr;
        exp_q.push_back(e);
    endtask

    // Leaves us just after the edge that sets sTick, fixing the sample phase.
    task automatic align();
        do begin
            @(posedge clk);
            #1;
        end while (sTick !== 1'b1);
    endtask

    task automatic line(input logic v, input int clks);
        rx = v;
        repeat (clks) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_clks);
        line(1'b0, 64);
        for (int i = 0; i < 8; i++) line(d[i], 64);
`ifdef UART_RX_PARITY_EN
        line((^d) ^ par_flip, 64);
`endif
        line(stop, stop_clks);
    endtask

    task automatic wait_done(input int target, input int budget);
        int k;
        k = 0;
        while (done_count < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("done_count", 32'(done_count), 32'(target));
    endtask

    initial begin
        // 1. reset and idle line
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        line(1'b1, 400);
        check("reset_dout", 32'(dout), 32'h0);
        check("reset_frameErr", 32'(frameErr), 32'h0);
        check("reset_done", 32'(rxDoneTick), 32'h0);
        check("idle_no_done", 32'(done_count), 32'd0);
`ifdef UART_RX_PARITY_EN
        check("reset_parityErr", 32'(parityErr), 32'h0);
`endif

        // 2. good frame
        push(8'hA5, 1'b0, 1'b0);
        align();
        send_frame(8'hA5, 1'b1, 64);
        wait_done(1, 200);
        line(1'b1, 200);
        check("hold_dout_A5", 32'(dout), 32'hA5);

        // 3. short glitch rejected
        align();
        line(1'b0, 16);
        line(1'b1, 700);
        check("glitch_no_done", 32'(done_count), 32'd1);
        check("glitch_dout", 32'(dout), 32'hA5);

        // 4. framing error, then recovery
        push(8'h3C, 1'b1, 1'b0);
        align();
        send_frame(8'h3C, 1'b0, 64);
        line(1'b1, 64);
        wait_done(2, 200);
        push(8'h81, 1'b0, 1'b0);
        align();
        send_frame(8'h81, 1'b1, 64);
        wait_done(3, 200);
        line(1'b1, 64);

        // 5. back-to-back: next start edge lands right after the stop sample
        push(8'h00, 1'b0, 1'b0);
        push(8'hFF, 1'b0, 1'b0);
        align();
        send_frame(8'h00, 1'b1, 32);
        send_frame(8'hFF, 1'b1, 64);
        wait_done(5, 200);
        if (done_cyc.size() >= 5)
            check("b2b_spacing", 32'(done_cyc[4] - done_cyc[3]), 32'(FRAME_CLKS));
        line(1'b1, 64);

        // 6. reset during data bit 4 of 0x55
        align();
        line(1'b0, 64);
        line(1'b1, 64);
        line(1'b0, 64);
        line(1'b1, 64);
        line(1'b0, 64);
        line(1'b1, 32);
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midreset_dout", 32'(dout), 32'h0);
        check("midreset_frameErr", 32'(frameErr), 32'h0);
        check("midreset_done", 32'(rxDoneTick), 32'h0);
        reset = 1'b0;
        line(1'b1, 800);
        check("midreset_no_done", 32'(done_count), 32'd5);
        push(8'h12, 1'b0, 1'b0);
        align();
        send_frame(8'h12, 1'b1, 64);
        wait_done(6, 200);
        line(1'b1, 64);

`ifdef UART_RX_PARITY_EN
        push(8'h07, 1'b0, 1'b1);
        par_flip = 1'b1;
        align();
        send_frame(8'h07, 1'b1, 64);
        wait_done(7, 200);
        par_flip = 1'b0;
        push(8'h07, 1'b0, 1'b0);
        align();
        send_frame(8'h07, 1'b1, 64);
        wait_done(8, 200);
        line(1'b1, 64);
`endif

        line(1'b1, 200);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("final_dout", 32'(dout), (PBITS != 0) ? 32'h07 : 32'h12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
